// File: rtl/multi_dataflow_job_sequencer.sv
// Job sequencer between a multi-stream streamer and a dataflow engine.
// Ports: clk_i/rst_i/clear_i; start_i + len_i/in_mask_i/out_mask_i job config;
//   in_valid_i/in_data_i/in_ready_o source streams joined into a one-entry
//   slice on eng_valid_o/eng_data_o/eng_ready_i; eng_out_* results passed
//   through to out_valid_o/out_data_o/out_ready_i; busy_o, done_o, beat counts.
module multi_dataflow_job_sequencer #(
   parameter int N_IN       = 2,
   parameter int N_OUT      = 1,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        clear_i,
   input  logic                        start_i,
   input  logic [CNT_WIDTH-1:0]        len_i,
   input  logic [N_IN-1:0]             in_mask_i,
   input  logic [N_OUT-1:0]            out_mask_i,
   input  logic [N_IN-1:0]             in_valid_i,
   input  logic [N_IN*DATA_WIDTH-1:0]  in_data_i,
   output logic [N_IN-1:0]             in_ready_o,
   output logic                        eng_valid_o,
   output logic [N_IN*DATA_WIDTH-1:0]  eng_data_o,
   input  logic                        eng_ready_i,
   input  logic [N_OUT-1:0]            eng_out_valid_i,
   input  logic [N_OUT*DATA_WIDTH-1:0] eng_out_data_i,
   output logic [N_OUT-1:0]            eng_out_ready_o,
   output logic [N_OUT-1:0]            out_valid_o,
   output logic [N_OUT*DATA_WIDTH-1:0] out_data_o,
   input  logic [N_OUT-1:0]            out_ready_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic [CNT_WIDTH-1:0]        in_cnt_o,
   output logic [N_OUT*CNT_WIDTH-1:0]  out_cnt_o
);

   localparam int CW = CNT_WIDTH;
   localparam int DW = DATA_WIDTH;
   localparam logic [CW-1:0] ONE = 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t                 state_q;
   logic [CW-1:0]          len_q;
   logic [CW-1:0]          in_cnt_q;
   logic [N_OUT*CW-1:0]    out_cnt_q;
   logic [N_IN-1:0]        in_mask_q;
   logic [N_OUT-1:0]       out_mask_q;
   logic                   slice_vld_q;
   logic [N_IN*DW-1:0]     slice_dat_q;
   logic                   busy_q;
   logic                   done_q;

   logic                   run;
   logic                   in_done;
   logic                   out_done;
   logic                   all_vld;
   logic                   in_fire;
   logic [N_IN*DW-1:0]     join_dat;
   logic [N_OUT-1:0]       out_gate;
   logic [N_OUT-1:0]       out_fire;

   assign run     = (state_q == S_RUN);
   assign in_done = (in_cnt_q == len_q) || (in_mask_q == '0);

   // Disabled channels count as valid so they never block the join.
   assign all_vld = &(in_valid_i | ~in_mask_q);
   assign in_fire = run & ~in_done & all_vld & (~slice_vld_q | eng_ready_i);

   // A disabled output channel is trivially complete, so an all-zero
   // mask falls out as complete as well.
   always_comb begin
      out_done = 1'b1;
      for (int j = 0; j < N_OUT; j++) begin
         if (out_mask_q[j] && (out_cnt_q[j*CW +: CW] != len_q))
            out_done = 1'b0;
      end
   end

   always_comb begin
      join_dat = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (in_mask_q[i])
            join_dat[i*DW +: DW] = in_data_i[i*DW +: DW];
      end
   end

   always_comb begin
      out_gate = '0;
      for (int j = 0; j < N_OUT; j++) begin
         out_gate[j] = out_mask_q[j] & run &
                       (out_cnt_q[j*CW +: CW] < len_q);
      end
   end

   assign out_valid_o     = eng_out_valid_i & out_gate;
   assign eng_out_ready_o = out_ready_i & out_gate;
   assign out_fire        = out_valid_o & out_ready_i;
   assign out_data_o      = eng_out_data_i;

   assign in_ready_o  = in_fire ? in_mask_q : '0;
   assign eng_valid_o = slice_vld_q;
   assign eng_data_o  = slice_dat_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign in_cnt_o    = in_cnt_q;
   assign out_cnt_o   = out_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         in_mask_q   <= '0;
         out_mask_q  <= '0;
         slice_vld_q <= 1'b0;
         slice_dat_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // A new beat overwrites the slice even while it drains.
         if (in_fire) begin
            slice_vld_q <= 1'b1;
            slice_dat_q <= join_dat;
         end else if (eng_ready_i) begin
            slice_vld_q <= 1'b0;
         end

         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  len_q      <= len_i;
                  in_mask_q  <= in_mask_i;
                  out_mask_q <= out_mask_i;
                  in_cnt_q   <= '0;
                  out_cnt_q  <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= S_RUN;
               end
            end
            S_RUN: begin
               if (in_fire)
                  in_cnt_q <= in_cnt_q + ONE;
               for (int j = 0; j < N_OUT; j++) begin
                  if (out_fire[j])
                     out_cnt_q[j*CW +: CW] <= out_cnt_q[j*CW +: CW] + ONE;
               end
               if (in_done && out_done) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multi_dataflow_job_sequencer.sv
// Scoreboard bench for multi_dataflow_job_sequencer (N_IN=2, N_OUT=1).
// Stimulus pushes expected engine beats; a negedge monitor pops and compares.
module tb_multi_dataflow_job_sequencer;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        clear_i;
   logic        start_i;
   logic [15:0] len_i;
   logic [1:0]  in_mask_i;
   logic [0:0]  out_mask_i;
   logic [1:0]  in_valid_i;
   logic [63:0] in_data_i;
   logic [1:0]  in_ready_o;
   logic        eng_valid_o;
   logic [63:0] eng_data_o;
   logic        eng_ready_i;
   logic [0:0]  eng_out_valid_i;
   logic [31:0] eng_out_data_i;
   logic [0:0]  eng_out_ready_o;
   logic [0:0]  out_valid_o;
   logic [31:0] out_data_o;
   logic [0:0]  out_ready_i;
   logic        busy_o;
   logic        done_o;
   logic [15:0] in_cnt_o;
   logic [15:0] out_cnt_o;

   multi_dataflow_job_sequencer #(
      .N_IN(2), .N_OUT(1), .DATA_WIDTH(32), .CNT_WIDTH(16)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
      .len_i(len_i), .in_mask_i(in_mask_i), .out_mask_i(out_mask_i),
      .in_valid_i(in_valid_i), .in_data_i(in_data_i),
      .in_ready_o(in_ready_o),
      .eng_valid_o(eng_valid_o), .eng_data_o(eng_data_o),
      .eng_ready_i(eng_ready_i),
      .eng_out_valid_i(eng_out_valid_i), .eng_out_data_i(eng_out_data_i),
      .eng_out_ready_o(eng_out_ready_o),
      .out_valid_o(out_valid_o), .out_data_o(out_data_o),
      .out_ready_i(out_ready_i),
      .busy_o(busy_o), .done_o(done_o),
      .in_cnt_o(in_cnt_o), .out_cnt_o(out_cnt_o)
   );

   always #5 clk = ~clk;

   logic [63:0] exp_q[$];
   int vec_cnt = 0;
   int err_cnt = 0;
   int done_cnt = 0;
   int cyc = 0;
   int first_fire = -1;
   int first_vld = -1;
   bit arm = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s: got timeout/unexpected expected event", nm);
   endtask

   always @(posedge clk) cyc++;

   // Monitor: slice contents must equal the oldest outstanding beat every
   // cycle it is valid, which also proves stability under backpressure.
   always @(negedge clk) begin
      if (!rst_i) begin
         if (done_o) done_cnt++;
         if (arm) begin
            if (first_fire < 0 && in_ready_o[0]) first_fire = cyc;
            if (first_vld < 0 && eng_valid_o) first_vld = cyc;
         end
         if (eng_valid_o) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_beat");
            end else begin
               chk("eng_data", eng_data_o, exp_q[0]);
               if (eng_ready_i) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int len, input logic [1:0] im,
                            input logic om);
      len_i      = 16'(len);
      in_mask_i  = im;
      out_mask_i = om;
      start_i    = 1'b1;
      step();
      start_i    = 1'b0;
   endtask

   task automatic send_beats(input int n, input logic [31:0] base,
                             input logic [1:0] m, input bit aa,
                             input int gap_at, input int gap_len);
      logic [31:0] l0;
      logic [31:0] l1;
      int t;
      for (int k = 0; k < n; k++) begin
         l0 = base + 32'(k);
         l1 = aa ? 32'hAAAA_AAAA : ~(base + 32'(k));
         in_data_i = {l1, l0};
         if (k == gap_at) begin
            in_valid_i = 2'b01;
            for (int g = 0; g < gap_len; g++) begin
               @(negedge clk);
               chk("gap_in_ready", 64'(in_ready_o), 64'd0);
               step();
            end
         end
         in_valid_i = 2'b11;
         exp_q.push_back({m[1] ? l1 : 32'h0, m[0] ? l0 : 32'h0});
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!in_ready_o[0] && t < 100);
         if (!in_ready_o[0]) begin
            fail_now("beat_timeout");
            in_valid_i = 2'b00;
            return;
         end
         chk("in_ready_lane1", 64'(in_ready_o[1]), 64'(m[1]));
         step();
      end
      in_valid_i = 2'b00;
   endtask

   task automatic wait_done();
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!done_o && t < 200);
      if (!done_o) fail_now("done_timeout");
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_i = 1'b1;
      clear_i = 1'b0;
      start_i = 1'b0;
      len_i = '0;
      in_mask_i = '0;
      out_mask_i = '0;
      in_valid_i = '0;
      in_data_i = '0;
      eng_ready_i = 1'b1;
      eng_out_valid_i = 1'b1;
      eng_out_data_i = 32'h5A5A_0001;
      out_ready_i = 1'b1;
      repeat (3) step();
      @(negedge clk);
      chk("rst_eng_valid", 64'(eng_valid_o), 64'd0);
      chk("rst_in_ready", 64'(in_ready_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_in_cnt", 64'(in_cnt_o), 64'd0);
      chk("rst_out_cnt", 64'(out_cnt_o), 64'd0);
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_eng_data", eng_data_o, 64'd0);
      step();
      rst_i = 1'b0;
      step();

      // Basic job: len 4, all enabled, always ready.
      done_cnt = 0;
      arm = 1'b1;
      start_job(4, 2'b11, 1'b1);
      @(negedge clk);
      chk("t1_busy", 64'(busy_o), 64'd1);
      chk("t1_out_valid", 64'(out_valid_o), 64'd1);
      chk("t1_eng_out_ready", 64'(eng_out_ready_o), 64'd1);
      chk("t1_out_data", 64'(out_data_o), 64'h5A5A_0001);
      step();
      send_beats(4, 32'h100, 2'b11, 1'b0, -1, 0);
      wait_done();
      repeat (3) step();
      arm = 1'b0;
      chk("t1_latency", 64'(first_vld - first_fire), 64'd1);
      chk("t1_done_pulses", 64'(done_cnt), 64'd1);
      chk("t1_in_cnt", 64'(in_cnt_o), 64'd4);
      chk("t1_out_cnt", 64'(out_cnt_o), 64'd4);
      chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("t1_busy_idle", 64'(busy_o), 64'd0);

      // Lane 1 valid gap mid-job.
      done_cnt = 0;
      start_job(6, 2'b11, 1'b1);
      send_beats(6, 32'h200, 2'b11, 1'b0, 3, 3);
      wait_done();
      repeat (2) step();
      chk("t2_in_cnt", 64'(in_cnt_o), 64'd6);
      chk("t2_done_pulses", 64'(done_cnt), 64'd1);
      chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

      // Engine backpressure for 5 cycles.
      done_cnt = 0;
      start_job(8, 2'b11, 1'b1);
      fork
         send_beats(8, 32'h300, 2'b11, 1'b0, -1, 0);
         begin
            step();
            step();
            eng_ready_i = 1'b0;
            for (int b = 0; b < 5; b++) begin
               @(negedge clk);
               chk("t3_bp_in_ready", 64'(in_ready_o), 64'd0);
               chk("t3_bp_eng_valid", 64'(eng_valid_o), 64'd1);
               step();
            end
            eng_ready_i = 1'b1;
         end
      join
      wait_done();
      repeat (2) step();
      chk("t3_in_cnt", 64'(in_cnt_o), 64'd8);
      chk("t3_done_pulses", 64'(done_cnt), 64'd1);
      chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

      // Lane 1 disabled: its data and ready must stay zero.
      done_cnt = 0;
      start_job(4, 2'b01, 1'b1);
      send_beats(4, 32'h400, 2'b01, 1'b1, -1, 0);
      wait_done();
      repeat (2) step();
      chk("t4_in_cnt", 64'(in_cnt_o), 64'd4);
      chk("t4_done_pulses", 64'(done_cnt), 64'd1);
      chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

      // Zero-length job.
      done_cnt = 0;
      start_job(0, 2'b11, 1'b1);
      @(negedge clk);
      chk("t5_run_done", 64'(done_o), 64'd0);
      chk("t5_run_busy", 64'(busy_o), 64'd1);
      chk("t5_run_in_ready", 64'(in_ready_o), 64'd0);
      chk("t5_run_eng_out_ready", 64'(eng_out_ready_o), 64'd0);
      step();
      @(negedge clk);
      chk("t5_done", 64'(done_o), 64'd1);
      chk("t5_in_cnt", 64'(in_cnt_o), 64'd0);
      chk("t5_out_cnt", 64'(out_cnt_o), 64'd0);
      repeat (3) step();
      chk("t5_done_pulses", 64'(done_cnt), 64'd1);

      // Start pulse during RUN must be ignored.
      done_cnt = 0;
      start_job(6, 2'b11, 1'b1);
      step();
      start_job(1, 2'b01, 1'b0);
      @(negedge clk);
      chk("t6_busy", 64'(busy_o), 64'd1);
      chk("t6_in_cnt", 64'(in_cnt_o), 64'd0);
      step();
      send_beats(6, 32'h600, 2'b11, 1'b0, -1, 0);
      wait_done();
      repeat (2) step();
      chk("t6_in_cnt_final", 64'(in_cnt_o), 64'd6);
      chk("t6_done_pulses", 64'(done_cnt), 64'd1);

      // Soft clear after 2 of 8 beats, then a len-3 job.
      done_cnt = 0;
      start_job(8, 2'b11, 1'b1);
      send_beats(2, 32'h700, 2'b11, 1'b0, -1, 0);
      repeat (3) step();
      chk("t7_queue_drained", 64'(exp_q.size()), 64'd0);
      chk("t7_in_cnt_mid", 64'(in_cnt_o), 64'd2);
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      @(negedge clk);
      chk("t7_busy", 64'(busy_o), 64'd0);
      chk("t7_in_cnt", 64'(in_cnt_o), 64'd0);
      chk("t7_out_cnt", 64'(out_cnt_o), 64'd0);
      repeat (4) step();
      chk("t7_no_done", 64'(done_cnt), 64'd0);
      start_job(3, 2'b11, 1'b1);
      send_beats(3, 32'h800, 2'b11, 1'b0, -1, 0);
      wait_done();
      repeat (2) step();
      chk("t7_in_cnt_final", 64'(in_cnt_o), 64'd3);
      chk("t7_done_pulses", 64'(done_cnt), 64'd1);

      // Reset mid-RUN with a beat held in the slice.
      start_job(8, 2'b11, 1'b1);
      eng_ready_i = 1'b0;
      in_data_i = {32'h9999_0000, 32'h0000_9999};
      in_valid_i = 2'b11;
      exp_q.push_back({32'h9999_0000, 32'h0000_9999});
      repeat (3) step();
      rst_i = 1'b1;
      step();
      @(negedge clk);
      chk("t8_eng_valid", 64'(eng_valid_o), 64'd0);
      chk("t8_in_ready", 64'(in_ready_o), 64'd0);
      chk("t8_out_valid", 64'(out_valid_o), 64'd0);
      chk("t8_eng_out_ready", 64'(eng_out_ready_o), 64'd0);
      chk("t8_busy", 64'(busy_o), 64'd0);
      chk("t8_in_cnt", 64'(in_cnt_o), 64'd0);
      exp_q.delete();
      step();
      rst_i = 1'b0;
      in_valid_i = 2'b00;
      eng_ready_i = 1'b1;
      repeat (2) step();

      $display("== %0d vectors applied, %0d miscompares ==",
               vec_cnt, err_cnt);
      $finish;
   end

endmodule
